// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock-enable divider (CLK_OUT + TICK per channel).
// Define CLK_DIV_HOLDOFF_EN to hold all channels idle for HOLD_CYCLES after reset.
module clk_div_multi #(
  parameter  int N_CH        = 2,
  parameter  int CNT_W       = 8,
  parameter  int INIT_DIV    = 4,
  parameter  int HOLD_CYCLES = 16,
  localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             MASTER_CLK,
  input  logic             RESET,
  input  logic [N_CH-1:0]  EN,
  input  logic             SYNC,
  input  logic             CFG_VALID,
  output logic             CFG_READY,
  input  logic [CH_W-1:0]  CFG_CH,
  input  logic [CNT_W-1:0] CFG_DIV,
  output logic [N_CH-1:0]  PENDING,
  output logic [N_CH-1:0]  CLK_OUT,
  output logic [N_CH-1:0]  TICK
`ifdef CLK_DIV_HOLDOFF_EN
  ,
  output logic             HOLDOFF_DONE
`endif
);

  if (N_CH < 1 || CNT_W < 2 || HOLD_CYCLES < 1) begin : g_param_chk
    $error("clk_div_multi: bad parameters");
  end

  localparam logic [CNT_W-1:0] INIT_C =
    (INIT_DIV < 2) ? CNT_W'(2) : CNT_W'(INIT_DIV);

  function automatic logic [CNT_W-1:0] clamp(
    input logic [CNT_W-1:0] v
  );
    return (v < CNT_W'(2)) ? CNT_W'(2) : v;
  endfunction

  logic [CNT_W-1:0] cnt_q  [N_CH];
  logic [CNT_W-1:0] cnt_d  [N_CH];
  logic [CNT_W-1:0] div_q  [N_CH];
  logic [CNT_W-1:0] div_d  [N_CH];
  logic [CNT_W-1:0] dpnd_q [N_CH];
  logic [CNT_W-1:0] dpnd_d [N_CH];

  logic [N_CH-1:0] pend_q, pend_d;
  logic [N_CH-1:0] clk_q, clk_d;
  logic [N_CH-1:0] tick_q, tick_d;
  logic [N_CH-1:0] run, apply;
  logic            hold, rls, xfer;

`ifdef CLK_DIV_HOLDOFF_EN
  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [HC_W-1:0] hcnt_q;
  logic            done_q;

  always_ff @(posedge MASTER_CLK) begin
    if (RESET) begin
      hcnt_q <= '0;
      done_q <= 1'b0;
    end else if (!done_q) begin
      if (rls) done_q <= 1'b1;
      else     hcnt_q <= hcnt_q + HC_W'(1);
    end
  end

  assign hold = ~done_q;
  assign rls  = ~done_q & (hcnt_q == HC_W'(HOLD_CYCLES - 1));
  assign HOLDOFF_DONE = done_q;
`else
  assign hold = 1'b0;
  assign rls  = 1'b0;
`endif

  assign run  = EN & {N_CH{~hold}};
  assign xfer = CFG_VALID & CFG_READY;

  // Out-of-range channel numbers are always ready and simply dropped.
  always_comb begin
    CFG_READY = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      if (CFG_CH == CH_W'(i)) CFG_READY = ~pend_q[i];
    end
  end

  always_comb begin
    apply  = '0;
    pend_d = pend_q;
    clk_d  = '0;
    tick_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i]  = cnt_q[i];
      div_d[i]  = div_q[i];
      dpnd_d[i] = dpnd_q[i];
      unique case (1'b1)
        !run[i]: begin
          cnt_d[i] = '0;
          apply[i] = ~hold | rls;
        end
        run[i] && (SYNC || cnt_q[i] >= div_q[i] - CNT_W'(1)): begin
          cnt_d[i] = '0;
          apply[i] = 1'b1;
        end
        default: cnt_d[i] = cnt_q[i] + CNT_W'(1);
      endcase
      if (apply[i] && pend_q[i]) begin
        div_d[i]  = dpnd_q[i];
        pend_d[i] = 1'b0;
      end
      if (xfer && CFG_CH == CH_W'(i)) begin
        dpnd_d[i] = clamp(CFG_DIV);
        pend_d[i] = 1'b1;
      end
      // Outputs are decoded from the next count so they line up with it.
      clk_d[i]  = run[i] &&
                  (cnt_d[i] >= div_d[i] - (div_d[i] >> 1));
      tick_d[i] = run[i] && (cnt_d[i] == div_d[i] - CNT_W'(1));
    end
  end

  always_ff @(posedge MASTER_CLK) begin
    if (RESET) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]  <= '0;
        div_q[i]  <= INIT_C;
        dpnd_q[i] <= INIT_C;
      end
      pend_q <= '0;
      clk_q  <= '0;
      tick_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        div_q[i]  <= div_d[i];
        dpnd_q[i] <= dpnd_d[i];
      end
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign PENDING = pend_q;
  assign CLK_OUT = clk_q;
  assign TICK    = tick_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: directed scenarios with literal pins plus
// randomized traffic compared every cycle against a phase-based model.
module tb_clk_div_multi;

  localparam int NCH = 3;

  logic           MASTER_CLK = 1'b0;
  logic           RESET;
  logic [NCH-1:0] EN;
  logic           SYNC;
  logic           CFG_VALID;
  logic           CFG_READY;
  logic [1:0]     CFG_CH;
  logic [7:0]     CFG_DIV;
  logic [NCH-1:0] PENDING;
  logic [NCH-1:0] CLK_OUT;
  logic [NCH-1:0] TICK;

  int   errors = 0;
  int   checks = 0;
  bit   chk_on = 1'b0;

  int   m_ph   [NCH];
  int   m_d    [NCH];
  int   m_dp   [NCH];
  bit   m_pend [NCH];

  logic [15:0] c0, c1, t0, t1;

  clk_div_multi #(
    .N_CH(NCH), .CNT_W(8), .INIT_DIV(4), .HOLD_CYCLES(16)
  ) dut (
    .MASTER_CLK(MASTER_CLK),
    .RESET(RESET),
    .EN(EN),
    .SYNC(SYNC),
    .CFG_VALID(CFG_VALID),
    .CFG_READY(CFG_READY),
    .CFG_CH(CFG_CH),
    .CFG_DIV(CFG_DIV),
    .PENDING(PENDING),
    .CLK_OUT(CLK_OUT),
    .TICK(TICK)
  );

  always #5 MASTER_CLK = ~MASTER_CLK;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int clampd(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  function automatic bit exp_ready();
    if (int'(CFG_CH) >= NCH) return 1'b1;
    return !m_pend[int'(CFG_CH)];
  endfunction

  // Square wave is high while the cycles left in the period are <= D/2.
  function automatic bit exp_clk(input int i);
    return (m_d[i] - m_ph[i]) <= (m_d[i] / 2);
  endfunction

  function automatic bit exp_tick(input int i);
    return m_ph[i] == m_d[i] - 1;
  endfunction

  initial begin
    for (int i = 0; i < NCH; i++) begin
      m_ph[i] = 0; m_d[i] = 4; m_dp[i] = 4; m_pend[i] = 1'b0;
    end
  end

  // Model: phase within the current period, active and queued divisor.
  always @(posedge MASTER_CLK) begin
    if (RESET) begin
      for (int i = 0; i < NCH; i++) begin
        m_ph[i] = 0; m_d[i] = 4; m_pend[i] = 1'b0;
      end
    end else begin
      bit acc;
      acc = CFG_VALID && exp_ready();
      for (int i = 0; i < NCH; i++) begin
        if (!EN[i] || SYNC || m_ph[i] + 1 == m_d[i]) begin
          m_ph[i] = 0;
          if (m_pend[i]) begin
            m_d[i] = m_dp[i];
            m_pend[i] = 1'b0;
          end
        end else begin
          m_ph[i] = m_ph[i] + 1;
        end
        if (acc && int'(CFG_CH) == i) begin
          m_dp[i] = clampd(int'(CFG_DIV));
          m_pend[i] = 1'b1;
        end
      end
    end
  end

  always @(negedge MASTER_CLK) begin
    if (chk_on) begin
      for (int i = 0; i < NCH; i++) begin
        chk($sformatf("clk_out[%0d]", i), 32'(CLK_OUT[i]), 32'(exp_clk(i)));
        chk($sformatf("tick[%0d]", i), 32'(TICK[i]), 32'(exp_tick(i)));
        chk($sformatf("pending[%0d]", i), 32'(PENDING[i]),
            32'(m_pend[i]));
      end
      chk("cfg_ready", 32'(CFG_READY), 32'(exp_ready()));
    end
  end

  task automatic next();
    @(posedge MASTER_CLK);
    #1;
  endtask

  task automatic cap(input int n);
    c0 = '0; c1 = '0; t0 = '0; t1 = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge MASTER_CLK);
      c0[k] = CLK_OUT[0]; c1[k] = CLK_OUT[1];
      t0[k] = TICK[0];    t1[k] = TICK[1];
      next();
    end
  endtask

  task automatic wait_clear(input int ch);
    int n;
    n = 0;
    while (PENDING[ch] && n < 600) begin
      next();
      n++;
    end
    chk("pend_clear", 32'(PENDING[ch]), 32'd0);
  endtask

  task automatic write(input int ch, input int dv);
    CFG_CH = 2'(ch); CFG_DIV = 8'(dv); CFG_VALID = 1'b1;
    next();
    CFG_VALID = 1'b0;
  endtask

  initial begin
    int k, r;
    RESET = 1'b1; EN = '0; SYNC = 1'b0;
    CFG_VALID = 1'b0; CFG_CH = '0; CFG_DIV = '0;
    next(); next();
    RESET = 1'b0; EN = '1; chk_on = 1'b1;

    // D=4 after reset
    cap(12);
    chk("rst_clk0", 32'(c0[11:0]), 32'h0CCC);
    chk("rst_clk1", 32'(c1[11:0]), 32'h0CCC);
    chk("rst_tick1", 32'(t1[11:0]), 32'h0888);

    // ch1 DIV=5 written at cnt=1, second write stalls
    next();
    CFG_CH = 2'd1; CFG_DIV = 8'd5; CFG_VALID = 1'b1;
    next();
    chk("pend1_set", 32'(PENDING[1]), 32'd1);
    chk("ready1_low", 32'(CFG_READY), 32'd0);
    next(); next();
    cap(10);
    CFG_VALID = 1'b0;
    chk("d5_clk1", 32'(c1[9:0]), 32'h318);
    chk("d5_tick1", 32'(t1[9:0]), 32'h210);

    // DIV 0 and 1 clamp to 2
    write(0, 0);
    wait_clear(0);
    cap(6);
    chk("d0_clk0", 32'(c0[5:0]), 32'h2A);
    chk("d0_tick0", 32'(t0[5:0]), 32'h2A);
    write(0, 1);
    wait_clear(0);
    cap(6);
    chk("d1_clk0", 32'(c0[5:0]), 32'h2A);
    chk("d1_tick0", 32'(t0[5:0]), 32'h2A);

    // SYNC aligns D=4 and D=6
    write(0, 4);
    wait_clear(0);
    write(1, 6);
    wait_clear(1);
    repeat ($urandom_range(0, 5)) next();
    SYNC = 1'b1;
    next();
    SYNC = 1'b0;
    cap(4);
    chk("sync_clk0", 32'(c0[3:0]), 32'hC);
    chk("sync_clk1", 32'(c1[3:0]), 32'h8);

    // EN drop with pending DIV=3
    next();
    write(0, 3);
    chk("pend0_set", 32'(PENDING[0]), 32'd1);
    EN[0] = 1'b0;
    next();
    chk("endrop_clk0", 32'(CLK_OUT[0]), 32'd0);
    chk("endrop_tick0", 32'(TICK[0]), 32'd0);
    chk("endrop_pend0", 32'(PENDING[0]), 32'd0);
    EN[0] = 1'b1;
    cap(3);
    chk("d3_clk0", 32'(c0[2:0]), 32'h4);

    // RESET with a pending write
    write(1, 7);
    RESET = 1'b1;
    next();
    RESET = 1'b0;
    chk("rst2_clk", 32'(CLK_OUT), 32'd0);
    chk("rst2_tick", 32'(TICK), 32'd0);
    chk("rst2_pend", 32'(PENDING), 32'd0);
    chk("rst2_ready", 32'(CFG_READY), 32'd1);
    cap(4);
    chk("rst2_clk0", 32'(c0[3:0]), 32'hC);
    chk("rst2_clk1", 32'(c1[3:0]), 32'hC);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      RESET = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 24) == 0) begin
        k = $urandom_range(0, NCH - 1);
        EN[k] = ~EN[k];
      end
      SYNC = ($urandom_range(0, 39) == 0);
      CFG_VALID = ($urandom_range(0, 3) == 0);
      CFG_CH = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      if (r < 7)       CFG_DIV = 8'($urandom_range(0, 9));
      else if (r == 7) CFG_DIV = 8'd255;
      else if (r == 8) CFG_DIV = 8'd254;
      else             CFG_DIV = 8'($urandom_range(0, 255));
      next();
    end

    RESET = 1'b0; SYNC = 1'b0; CFG_VALID = 1'b0;
    next(); next();
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
